// File: rtl/apb_mem_slave_ws.sv
// rtl/apb_mem_slave_ws.sv - APB memory slave with wait states, byte strobes and error response; optional APB_MEM_RAND_WAIT_EN
module apb_mem_slave_ws #(
  parameter int    DATA_WIDTH    = 32,
  parameter int    ADDR_WIDTH    = 32,
  parameter int    DEPTH         = 1024,
  parameter int    WAIT_CYCLES   = 0,
  parameter string INIT_FILENAME = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] prdata_d;
  logic                  pready_d, pslverr_d;
  logic                  enter_done;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  setup;
  logic [IW-1:0]         live_idx;
  logic                  live_err;
  logic [3:0]            wait_sel;

  assign setup    = psel && !penable;
  assign live_idx = paddr[OFF+IW-1:OFF];
  assign live_err = (paddr[OFF-1:0] != '0) || ((paddr >> OFF) >= ADDR_WIDTH'(DEPTH));

`ifdef APB_MEM_RAND_WAIT_EN
  logic [7:0] lfsr_q;

  // Galois LFSR (x^8+x^6+x^5+x^4+1) stepped once per accepted setup phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
    end else if (state_q == S_IDLE && setup) begin
      lfsr_q <= {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    end
  end

  // The value present at setup picks this transfer's wait count
  assign wait_sel = 4'(32'(lfsr_q[3:0]) % (WAIT_CYCLES + 1));
`else
  assign wait_sel = 4'(WAIT_CYCLES);
`endif

  // State, captured request and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      prdata  <= prdata_d;
      pready  <= pready_d;
      pslverr <= pslverr_d;
    end
  end

  // Next state, request capture and output values for the cycle being entered
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wr_d       = wr_q;
    err_d      = err_q;
    prdata_d   = prdata;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          idx_d = live_idx;
          wr_d  = pwrite;
          err_d = live_err;
          if (wait_sel == 4'd0) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = wait_sel - 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d    = S_DONE;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (enter_done) begin
      pready_d  = 1'b1;
      pslverr_d = err_d;
      prdata_d  = (!wr_d && !err_d) ? mem[idx_d] : '0;
    end
  end

  // Byte-lane write commit on the single DONE cycle; array is never reset
  always_ff @(posedge clk) begin
    if (state_q == S_DONE && wr_q && !err_q) begin
      for (int i = 0; i < NB; i++) begin
        if (pstrb[i]) mem[idx_q][i*8 +: 8] <= pwdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave_ws.sv
// tb/tb_apb_mem_slave_ws.sv - scoreboard bench for apb_mem_slave_ws
module tb_apb_mem_slave_ws;

  localparam int DW = 32;
  localparam int AW = 32;
`ifdef APB_MEM_RAND_WAIT_EN
  localparam int WC = 7;
`else
  localparam int WC = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] paddr = '0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [DW-1:0] pwdata = '0;
  logic [3:0]    pstrb = '0;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  always #5 clk = ~clk;

  apb_mem_slave_ws #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1024), .WAIT_CYCLES(WC), .INIT_FILENAME("")
  ) dut (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  int         wcnt = 0;
  int         xfer_no = 0;
  logic [7:0] lfsr_m = 8'hA5;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic get_wait(output int w);
`ifdef APB_MEM_RAND_WAIT_EN
    w = int'(lfsr_m[3:0]) % (WC + 1);
    lfsr_m = {1'b0, lfsr_m[7:1]} ^ (lfsr_m[0] ? 8'hB8 : 8'h00);
`else
    w = WC;
`endif
  endtask

  // One full transfer starting immediately; ends 1 ns after the DONE edge
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] er, input logic ee);
    exp_t e;
    int   nw;
    int   n;
    get_wait(nw);
    e.rdata = er;
    e.err   = ee;
    e.waits = nw;
    exp_q.push_back(e);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d; pstrb = s;
    @(posedge clk); #1 penable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pready && n < 64);
    if (!pready) begin
      checks++;
      errors++;
      $display("FAIL timeout: pready never rose for addr %0h", a);
    end
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: counts wait cycles of the access phase and checks each completion
  always @(negedge clk) begin
    if (rst || !(psel && penable)) begin
      wcnt = 0;
    end else if (!pready) begin
      wcnt++;
    end else begin
      xfer_no++;
      if (exp_q.size() == 0) begin
        chk($sformatf("unexpected_pready_%0d", xfer_no), 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("prdata_%0d", xfer_no), 64'(prdata), 64'(mon_e.rdata));
        chk($sformatf("pslverr_%0d", xfer_no), 64'(pslverr), 64'(mon_e.err));
        chk($sformatf("waits_%0d", xfer_no), 64'(wcnt), 64'(mon_e.waits));
      end
      wcnt = 0;
    end
  end

  initial begin
    #2;
    chk("reset_pready", 64'(pready), 64'd0);
    chk("reset_pslverr", 64'(pslverr), 64'd0);
    chk("reset_prdata", 64'(prdata), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lfsr_m = 8'hA5;
    idle(1);

    xfer(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    xfer(32'h10, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
    xfer(32'h0, 1'b1, 32'h00000013, 4'hF, 32'h0, 1'b0);
    idle(1);
    xfer(32'h0, 1'b0, 32'h0, 4'h0, 32'h00000013, 1'b0);
    xfer(32'h20, 1'b1, 32'h11223344, 4'hF, 32'h0, 1'b0);
    xfer(32'h20, 1'b1, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
    xfer(32'h20, 1'b0, 32'h0, 4'hF, 32'h11BB33DD, 1'b0);
    xfer(32'h1000, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1);
    xfer(32'h3, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    xfer(32'h0, 1'b0, 32'h0, 4'hF, 32'h00000013, 1'b0);
    xfer(32'h10, 1'b1, 32'h12345678, 4'h0, 32'h0, 1'b0);
    xfer(32'h10, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
    xfer(32'h8, 1'b1, 32'h00000077, 4'hF, 32'h0, 1'b0);
    xfer(32'h8, 1'b0, 32'h0, 4'hF, 32'h00000077, 1'b0);

`ifndef APB_MEM_RAND_WAIT_EN
    // Master drops psel mid-wait: no completion, no memory effect
    psel = 1'b1; penable = 1'b0; paddr = 32'h8; pwrite = 1'b1; pwdata = 32'h99; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort_pready_%0d", i), 64'(pready), 64'd0);
    end
    @(posedge clk); #1;
    xfer(32'h8, 1'b0, 32'h0, 4'hF, 32'h00000077, 1'b0);

    // Reset during the second wait cycle of a write
    psel = 1'b1; penable = 1'b0; paddr = 32'h8; pwrite = 1'b1; pwdata = 32'h55; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("midrst_pready", 64'(pready), 64'd0);
    chk("midrst_pslverr", 64'(pslverr), 64'd0);
    chk("midrst_prdata", 64'(prdata), 64'd0);
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    xfer(32'h8, 1'b0, 32'h0, 4'hF, 32'h00000077, 1'b0);
`else
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) xfer(32'h10, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
      else            xfer(32'h20, 1'b0, 32'h0, 4'hF, 32'h11BB33DD, 1'b0);
    end
`endif

    idle(3);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
